instruction_fetch: RTL and testbench

- Instruction fetch stage of the single-cycle-memory MIPS sandbox core.
- Owns the fetch PC and drives the instruction memory controller port: word address, read enable, and tied-off write signals. Captures each returned instruction word with its PC into a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Supports stall (FIFO full), halt (fetch_en low) and branch/jump redirect with flush.

---
 rtl/instruction_fetch.sv | 132 +++++++++++++
 tb/tb_instruction_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC, reads instruction memory one word
// per cycle into a small prefetch FIFO and hands entries to decode via valid/ready.
module instruction_fetch #(
  parameter int          MEM_WIDTH  = 32,
  parameter int          MEM_SIZE   = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_en,
  input  logic                        redirect_en,
  input  logic [31:0]                 redirect_pc,
  output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
  output logic                        mem_read_en,
  output logic                        mem_write_en,
  output logic [MEM_WIDTH-1:0]        mem_write_val,
  input  logic [MEM_WIDTH-1:0]        mem_read_val,
  output logic                        inst_valid,
  output logic [MEM_WIDTH-1:0]        inst,
  output logic [31:0]                 inst_pc,
  input  logic                        inst_ready
);

  localparam int AW = $clog2(MEM_SIZE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [MEM_WIDTH-1:0] inst_buf_q [FIFO_DEPTH];
  logic [31:0]          pc_buf_q   [FIFO_DEPTH];
  logic                 push_en;
  logic                 pop_en;

  // Read enable depends only on registered state and fetch/redirect controls,
  // never on inst_ready, so a full FIFO blocks a push even during a pop.
  assign mem_read_en   = (state_q == RUN) && fetch_en && !redirect_en && (count_q < FULL_CNT);
  assign mem_addr      = fetch_pc_q[AW+1:2];
  assign mem_write_en  = 1'b0;
  assign mem_write_val = '0;

  assign push_en = mem_read_en;
  assign pop_en  = inst_valid && inst_ready && !redirect_en;

  assign inst_valid = (count_q != '0);
  assign inst       = inst_buf_q[rd_ptr_q];
  assign inst_pc    = pc_buf_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (redirect_en) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      state_d    = fetch_en ? RUN : IDLE;
    end else begin
      if (push_en) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_en) - CW'(pop_en);

      unique case (state_q)
        IDLE: begin
          if (fetch_en) state_d = RUN;
        end
        RUN: begin
          if (!fetch_en)                            state_d = IDLE;
          else if (push_en && count_d == FULL_CNT) state_d = STALL;
        end
        STALL: begin
          // No push can happen here, so any pop leaves room for the next read.
          if (pop_en) state_d = fetch_en ? RUN : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values computed in the always_comb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // NOTE: the buffer is only FIFO_DEPTH entries, so it is reset to keep inst and
  // inst_pc at zero out of reset; a deep RAM would be left unreset instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        inst_buf_q[i] <= '0;
        pc_buf_q[i]   <= '0;
      end
    end else if (push_en) begin
      inst_buf_q[wr_ptr_q] <= mem_read_val;
      pc_buf_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a queue of expected {pc, inst}
// entries is loaded when a fetch stream starts and consumed on every handshake.
module tb_instruction_fetch;

  localparam int MEM_SIZE = 256;
  localparam int AW       = $clog2(MEM_SIZE);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } sb_entry_t;

  logic          clk;
  logic          rst_n;
  logic          fetch_en;
  logic          redirect_en;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] mem_addr;
  logic          mem_read_en;
  logic          mem_write_en;
  logic [31:0]   mem_write_val;
  logic [31:0]   mem_read_val;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [31:0]   inst_pc;
  logic          inst_ready;

  sb_entry_t sb_q[$];
  int        n_checks = 0;
  int        n_fails  = 0;
  int        pops     = 0;
  int        p0;

  instruction_fetch #(
    .MEM_WIDTH (32),
    .MEM_SIZE  (MEM_SIZE),
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_en     (fetch_en),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .mem_addr     (mem_addr),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_write_val(mem_write_val),
    .mem_read_val (mem_read_val),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_ready   (inst_ready)
  );

  // Instruction memory: word k holds 32'h1000_0000 + k.
  assign mem_read_val = 32'h1000_0000 + {{(32 - AW){1'b0}}, mem_addr};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc >> 2) & (MEM_SIZE - 1));
  endfunction

  task automatic sb_stream(input logic [31:0] start_pc, input int n);
    sb_entry_t e;
    sb_q.delete();
    for (int i = 0; i < n; i++) begin
      e.pc   = start_pc + 32'(4 * i);
      e.word = exp_word(e.pc);
      sb_q.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    fetch_en    = 1'b0;
    inst_ready  = 1'b0;
    redirect_en = 1'b0;
    #1;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: sampled on the falling edge, a handshake seen here is the pop
  // that the next rising edge performs.
  always @(negedge clk) begin
    if (rst_n) begin
      check("write_en_zero", {31'b0, mem_write_en}, 32'h0);
      check("write_val_zero", mem_write_val, 32'h0);
      if (inst_valid && inst_ready && !redirect_en) begin
        pops++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_pop", inst_pc, 32'hFFFF_FFFF);
        end else begin
          sb_entry_t e;
          e = sb_q.pop_front();
          check("sb_inst_pc", inst_pc, e.pc);
          check("sb_inst", inst, e.word);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=done");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b1;
    fetch_en    = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_read_en", {31'b0, mem_read_en}, 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming from reset with decode always ready.
    fetch_en   = 1'b1;
    inst_ready = 1'b1;
    sb_stream(32'h0, 12);
    #1;
    check("idle_no_read", {31'b0, mem_read_en}, 32'h0);
    tick(1);
    check("first_read_en", {31'b0, mem_read_en}, 32'h1);
    check("first_read_addr", 32'(mem_addr), 32'h0);
    check("first_not_valid", {31'b0, inst_valid}, 32'h0);
    tick(1);
    check("first_valid", {31'b0, inst_valid}, 32'h1);
    check("first_inst_pc", inst_pc, 32'h0);
    check("first_inst", inst, 32'h1000_0000);
    p0 = pops;
    tick(4);
    check("throughput", 32'(pops - p0), 32'd4);

    // Back-pressure from reset: exactly two entries captured, head held.
    do_reset();
    fetch_en   = 1'b1;
    inst_ready = 1'b0;
    sb_stream(32'h0, 12);
    tick(3);
    check("stall_valid", {31'b0, inst_valid}, 32'h1);
    check("stall_inst", inst, 32'h1000_0000);
    check("stall_read_en", {31'b0, mem_read_en}, 32'h0);
    tick(3);
    check("stall_inst_held", inst, 32'h1000_0000);
    check("stall_pc_held", inst_pc, 32'h0);
    check("stall_read_en_held", {31'b0, mem_read_en}, 32'h0);
    inst_ready = 1'b1;
    tick(4);

    // Redirect while full with decode ready: nothing popped, restart at 0x40.
    inst_ready = 1'b0;
    tick(2);
    check("full_read_en", {31'b0, mem_read_en}, 32'h0);
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0043;
    inst_ready  = 1'b1;
    sb_stream(32'h40, 10);
    p0 = pops;
    tick(1);
    redirect_en = 1'b0;
    #1;
    check("redir_no_pop", 32'(pops - p0), 32'd0);
    check("redir_flushed", {31'b0, inst_valid}, 32'h0);
    check("redir_read_en", {31'b0, mem_read_en}, 32'h1);
    check("redir_addr", 32'(mem_addr), 32'h10);
    tick(1);
    check("redir_valid", {31'b0, inst_valid}, 32'h1);
    check("redir_inst_pc", inst_pc, 32'h40);
    tick(4);

    // Word address wraps at MEM_SIZE.
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_03F8;
    sb_stream(32'h3F8, 8);
    tick(1);
    redirect_en = 1'b0;
    #1;
    check("wrap_addr_fe", 32'(mem_addr), 32'hFE);
    tick(1);
    check("wrap_addr_ff", 32'(mem_addr), 32'hFF);
    tick(1);
    check("wrap_addr_0", 32'(mem_addr), 32'h0);
    tick(3);

    // Fetch PC wraps at 2^32.
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    sb_stream(32'hFFFF_FFFC, 8);
    tick(1);
    redirect_en = 1'b0;
    #1;
    check("pcwrap_addr", 32'(mem_addr), 32'hFF);
    tick(1);
    check("pcwrap_top_pc", inst_pc, 32'hFFFF_FFFC);
    tick(1);
    check("pcwrap_zero_pc", inst_pc, 32'h0);
    tick(2);

    // Halt with one entry buffered: it drains, no new reads, state returns to IDLE.
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0100;
    sb_stream(32'h100, 12);
    tick(1);
    redirect_en = 1'b0;
    tick(3);
    fetch_en = 1'b0;
    #1;
    check("halt_no_read", {31'b0, mem_read_en}, 32'h0);
    check("halt_has_entry", {31'b0, inst_valid}, 32'h1);
    tick(1);
    check("halt_drained", {31'b0, inst_valid}, 32'h0);
    check("halt_read_off", {31'b0, mem_read_en}, 32'h0);
    tick(2);
    check("halt_read_still_off", {31'b0, mem_read_en}, 32'h0);
    fetch_en = 1'b1;
    #1;
    check("halt_idle_state", {31'b0, mem_read_en}, 32'h0);
    tick(1);
    check("resume_read_en", {31'b0, mem_read_en}, 32'h1);
    tick(1);
    check("resume_valid", {31'b0, inst_valid}, 32'h1);
    tick(3);

    // Asynchronous reset between edges, then restart from RESET_PC.
    @(posedge clk);
    #1;
    check("pre_areset_valid", {31'b0, inst_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid", {31'b0, inst_valid}, 32'h0);
    check("areset_read_en", {31'b0, mem_read_en}, 32'h0);
    check("areset_inst_pc", inst_pc, 32'h0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_stream(32'h0, 8);
    tick(1);
    check("restart_read_en", {31'b0, mem_read_en}, 32'h1);
    check("restart_addr", 32'(mem_addr), 32'h0);
    tick(1);
    check("restart_valid", {31'b0, inst_valid}, 32'h1);
    check("restart_inst_pc", inst_pc, 32'h0);
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
